// File: rtl/multicycle_datapath.sv
// Multi-cycle R/I-type datapath: FETCH / EXECUTE / WRITEBACK sequencing,
// handshake instruction fetch with wait states, 8-op ALU and register file.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   instrMemAddr         fetch address (the PC)
//   instrReq             fetch request, high throughout FETCH
//   instrValid/instrCode instruction return from memory
//   instrLatched         instruction register, decoded by the control unit
//   aluOP, aluSrcImm     ALU control, sampled in EXECUTE
//   regFileWe            register write enable, sampled in WRITEBACK
//   retire               one-cycle pulse in WRITEBACK
//   state                FETCH=00, EXECUTE=01, WRITEBACK=10
module multicycle_datapath #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     REG_COUNT = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     PC_STEP   = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] instrMemAddr,
  output logic            instrReq,
  input  logic            instrValid,
  input  logic [31:0]     instrCode,
  output logic [31:0]     instrLatched,
  input  logic [2:0]      aluOP,
  input  logic            aluSrcImm,
  input  logic            regFileWe,
  output logic            retire,
  output logic [1:0]      state
);

  localparam int unsigned AW = $clog2(REG_COUNT);
  localparam int unsigned SW = $clog2(XLEN);

  localparam logic [1:0] S_FETCH = 2'b00;
  localparam logic [1:0] S_EXEC  = 2'b01;
  localparam logic [1:0] S_WB    = 2'b10;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] alu_out;
  logic            instr_req_q;
  logic            retire_q;
  logic [XLEN-1:0] regs [REG_COUNT];

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op_b;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;

  assign instrMemAddr = pc_q;
  assign instrReq     = instr_req_q;
  assign instrLatched = ir_q;
  assign retire       = retire_q;
  assign state        = state_q;

  // Register addresses are the low bits of the 5-bit instruction fields
  assign rs1 = ir_q[15 +: AW];
  assign rs2 = ir_q[20 +: AW];
  assign rd  = ir_q[7 +: AW];

  // x0 reads as zero regardless of storage contents
  assign rdata1 = (rs1 == '0) ? '0 : regs[rs1];
  assign rdata2 = (rs2 == '0) ? '0 : regs[rs2];

  assign imm   = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign op_b  = aluSrcImm ? imm : rdata2;
  assign shamt = op_b[SW-1:0];

  // ALU
  always_comb begin
    alu_res = '0;
    case (aluOP)
      3'b000: alu_res = rdata1 + op_b;
      3'b001: alu_res = rdata1 - op_b;
      3'b010: alu_res = rdata1 | op_b;
      3'b011: alu_res = rdata1 & op_b;
      3'b100: alu_res = rdata1 ^ op_b;
      3'b101: alu_res = rdata1 << shamt;
      3'b110: alu_res = rdata1 >> shamt;
      3'b111: alu_res = {{(XLEN-1){1'b0}}, ($signed(rdata1) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (instrValid) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Registered handshake / retire outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_req_q <= 1'b1;
      retire_q    <= 1'b0;
    end else begin
      instr_req_q <= (state_d == S_FETCH);
      retire_q    <= (state_d == S_WB);
    end
  end

  // PC, IR, ALU output register and register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      alu_out <= '0;
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= (i == 0) ? '0 : XLEN'(10 + i);
      end
    end else begin
      case (state_q)
        S_FETCH: if (instrValid) ir_q <= instrCode;
        S_EXEC:  alu_out <= alu_res;
        S_WB: begin
          if (regFileWe && (rd != '0)) regs[rd] <= alu_out;
          pc_q <= pc_q + XLEN'(PC_STEP);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath with a behavioural reference
// model (register array + PC) and a second instance exercising PC wrap.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrMemAddr;
  logic        instrReq;
  logic        instrValid;
  logic [31:0] instrCode;
  logic [31:0] instrLatched;
  logic [2:0]  aluOP;
  logic        aluSrcImm;
  logic        regFileWe;
  logic        retire;
  logic [1:0]  state;

  logic [31:0] w_addr;
  logic        w_req;
  logic [31:0] w_ir;
  logic        w_ret;
  logic [1:0]  w_state;

  always #5 clk = ~clk;

  multicycle_datapath dut (
    .clk(clk), .rst(rst), .instrMemAddr(instrMemAddr), .instrReq(instrReq),
    .instrValid(instrValid), .instrCode(instrCode), .instrLatched(instrLatched),
    .aluOP(aluOP), .aluSrcImm(aluSrcImm), .regFileWe(regFileWe),
    .retire(retire), .state(state)
  );

  multicycle_datapath #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .instrMemAddr(w_addr), .instrReq(w_req),
    .instrValid(instrValid), .instrCode(instrCode), .instrLatched(w_ir),
    .aluOP(aluOP), .aluSrcImm(aluSrcImm), .regFileWe(regFileWe),
    .retire(w_ret), .state(w_state)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] r_type(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input int rd, input int rs1, input logic [11:0] imm);
    return {imm, 5'(rs1), 3'b0, 5'(rd), 7'b0010011};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 0) ? 32'd0 : 32'(10 + i);
    m_pc = 32'd0;
  endtask

  // One full instruction: waits idle FETCH cycles, then the handshake,
  // checked cycle by cycle against the model; returns the retire cycle.
  task automatic run_instr(input logic [31:0] code, input logic [2:0] op, input logic src,
                           input logic we, input int waits, output int ret_cyc);
    logic [31:0] a, b, res;
    int rd, cyc;
    a   = m_regs[code[19:15]];
    b   = src ? {{20{code[31]}}, code[31:20]} : m_regs[code[24:20]];
    res = alu_ref(op, a, b);
    rd  = int'(code[11:7]);
    cyc = 1;
    ret_cyc = -1;
    aluOP = op; aluSrcImm = src; regFileWe = we;
    for (int w = 0; w < waits; w++) begin
      instrValid = 1'b0;
      instrCode  = $urandom;
      @(negedge clk); cyc++;
      checks++;
      if (state !== 2'b00 || instrReq !== 1'b1 || retire !== 1'b0 || instrMemAddr !== m_pc) begin
        errors++;
        $display("FAIL wait_fetch: state=%b req=%b retire=%b addr=%h want state=00 req=1 retire=0 addr=%h",
                 state, instrReq, retire, instrMemAddr, m_pc);
      end
    end
    instrValid = 1'b1;
    instrCode  = code;
    @(negedge clk); cyc++;
    checks++;
    if (state !== 2'b01 || instrLatched !== code || retire !== 1'b0) begin
      errors++;
      $display("FAIL execute: state=%b ir=%h retire=%b want state=01 ir=%h retire=0",
               state, instrLatched, retire, code);
    end
    instrValid = 1'($urandom);
    instrCode  = $urandom;
    @(negedge clk); cyc++;
    if (retire === 1'b1) ret_cyc = cyc;
    checks++;
    if (state !== 2'b10 || retire !== 1'b1 || dut.alu_out !== res) begin
      errors++;
      $display("FAIL writeback: state=%b retire=%b aluout=%h want state=10 retire=1 aluout=%h",
               state, retire, dut.alu_out, res);
    end
    instrValid = 1'($urandom);
    @(negedge clk);
    instrValid = 1'b0;
    if (we && rd != 0) m_regs[rd] = res;
    m_pc = m_pc + 32'd4;
    checks++;
    if (state !== 2'b00 || retire !== 1'b0 || instrReq !== 1'b1 || instrMemAddr !== m_pc) begin
      errors++;
      $display("FAIL next_fetch: state=%b retire=%b req=%b addr=%h want state=00 retire=0 req=1 addr=%h",
               state, retire, instrReq, instrMemAddr, m_pc);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.regs[i] !== m_regs[i]) begin
        errors++;
        $display("FAIL regfile x%0d: got %h want %h", i, dut.regs[i], m_regs[i]);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (state !== 2'b00 || instrMemAddr !== 32'd0 || instrLatched !== 32'd0 ||
        retire !== 1'b0 || instrReq !== 1'b1 || dut.alu_out !== 32'd0) begin
      errors++;
      $display("FAIL %s: state=%b addr=%h ir=%h retire=%b req=%b aluout=%h want 00/0/0/0/1/0",
               tag, state, instrMemAddr, instrLatched, retire, instrReq, dut.alu_out);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.regs[i] !== ((i == 0) ? 32'd0 : 32'(10 + i))) begin
        errors++;
        $display("FAIL %s_reg x%0d: got %h want %h", tag, i, dut.regs[i],
                 (i == 0) ? 32'd0 : 32'(10 + i));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; instrValid = 1'b0; instrCode = '0;
    aluOP = '0; aluSrcImm = 1'b0; regFileWe = 1'b0;
    @(negedge clk); @(negedge clk);
    check_reset_values("reset");
    checks++;
    if (w_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL reset_pc_param: got %h want fffffffc", w_addr);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_add();
    int rc;
    checks++;
    if (instrMemAddr !== 32'd0) begin
      errors++;
      $display("FAIL first_addr: got %h want 00000000", instrMemAddr);
    end
    run_instr(32'h0020_81B3, 3'b000, 1'b0, 1'b1, 0, rc);
    checks++;
    if (rc !== 3) begin errors++; $display("FAIL add_latency: got %0d want 3", rc); end
    checks++;
    if (dut.regs[3] !== 32'd23) begin errors++; $display("FAIL add_x3: got %0d want 23", dut.regs[3]); end
    checks++;
    if (instrMemAddr !== 32'd4) begin errors++; $display("FAIL add_next_pc: got %h want 4", instrMemAddr); end
  endtask

  task automatic test_pc_wrap();
    checks++;
    if (w_addr !== 32'd0) begin errors++; $display("FAIL pc_wrap: got %h want 00000000", w_addr); end
  endtask

  task automatic test_wait_states();
    int rc;
    run_instr(r_type(4, 1, 2), 3'b000, 1'b0, 1'b1, 5, rc);
    checks++;
    if (rc !== 8) begin errors++; $display("FAIL wait_latency: got %0d want 8", rc); end
  endtask

  task automatic test_alu_sweep();
    logic [31:0] exp_tbl [8];
    int rc;
    exp_tbl[0] = 32'd23;       exp_tbl[1] = 32'hFFFF_FFFF; exp_tbl[2] = 32'd15;
    exp_tbl[3] = 32'd8;        exp_tbl[4] = 32'd7;         exp_tbl[5] = 32'd45056;
    exp_tbl[6] = 32'd0;        exp_tbl[7] = 32'd1;
    for (int k = 0; k < 8; k++) begin
      run_instr(r_type(7, 1, 2), 3'(k), 1'b0, 1'b1, k % 2, rc);
      checks++;
      if (dut.regs[7] !== exp_tbl[k]) begin
        errors++;
        $display("FAIL alu_op%0d: got %h want %h", k, dut.regs[7], exp_tbl[k]);
      end
    end
  endtask

  task automatic test_immediate();
    int rc;
    run_instr(i_type(8, 1, 12'hFFF), 3'b000, 1'b1, 1'b1, 0, rc);
    checks++;
    if (dut.regs[8] !== 32'd10) begin errors++; $display("FAIL imm_add: got %0d want 10", dut.regs[8]); end
  endtask

  task automatic test_x0_and_back_to_back();
    int rc;
    run_instr(i_type(0, 1, 12'd88), 3'b000, 1'b1, 1'b1, 0, rc);
    run_instr(r_type(9, 0, 0), 3'b000, 1'b0, 1'b1, 0, rc);
    checks++;
    if (dut.regs[9] !== 32'd0) begin errors++; $display("FAIL x0_read: got %0d want 0", dut.regs[9]); end
    run_instr(r_type(5, 1, 2), 3'b000, 1'b0, 1'b1, 0, rc);
    run_instr(r_type(6, 5, 5), 3'b000, 1'b0, 1'b1, 0, rc);
    checks++;
    if (dut.regs[6] !== 32'd46) begin errors++; $display("FAIL raw_x6: got %0d want 46", dut.regs[6]); end
  endtask

  task automatic test_random();
    int rc;
    for (int n = 0; n < 40; n++) begin
      run_instr($urandom, 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), rc);
    end
  endtask

  task automatic test_reset_mid_execute();
    instrValid = 1'b1;
    instrCode  = r_type(4, 1, 2);
    aluOP = 3'b000; aluSrcImm = 1'b0; regFileWe = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL mid_pre_state: got %b want 01", state); end
    #2 rst = 1'b0;
    #1 check_reset_values("mid_reset");
    @(negedge clk);
    @(negedge clk);
    check_reset_values("mid_reset_hold");
    instrValid = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_add();
    test_pc_wrap();
    test_wait_states();
    test_alu_sweep();
    test_immediate();
    test_x0_and_back_to_back();
    test_random();
    test_reset_mid_execute();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
